// File: rtl/scan_display_if.sv
// Display-side bus of the multiplexed seven-segment scanner:
// frame data and controls in, digit enables and segments out.
interface scan_display_if #(
    parameter int DIGITS   = 4,
    parameter int BRIGHT_W = 3
);
    logic [4*DIGITS-1:0] i_bcd;
    logic [DIGITS-1:0]   i_dp;
    logic                i_blank_lz;
    logic [BRIGHT_W-1:0] i_brightness;
    logic                i_enable;
    logic [DIGITS-1:0]   o_pin;
    logic [6:0]          o_seg_7;
    logic                o_dp_out;
    logic                o_frame_tick;

    modport master (
        output i_bcd, i_dp, i_blank_lz, i_brightness, i_enable,
        input  o_pin, o_seg_7, o_dp_out, o_frame_tick
    );

    modport slave (
        input  i_bcd, i_dp, i_blank_lz, i_brightness, i_enable,
        output o_pin, o_seg_7, o_dp_out, o_frame_tick
    );
endinterface

// File: rtl/scan_display.sv
// Multiplexed seven-segment driver: prescaled digit scan, PWM dimming,
// leading-zero blanking, decimal points and tear-free frame snapshot.
module scan_display #(
    parameter int DIGITS     = 4,
    parameter int CLK_HZ     = 50000000,
    parameter int SCAN_HZ    = 2000,
    parameter int BRIGHT_W   = 3,
    parameter int ACTIVE_LOW = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    scan_display_if.slave  bus
);
    localparam int SLOT = CLK_HZ / SCAN_HZ;
    localparam int PW   = $clog2(SLOT);
    localparam int IW   = $clog2(DIGITS);
    localparam int SW   = 5 * DIGITS;
    localparam bit AL   = (ACTIVE_LOW != 0);
    localparam bit P_OK = (SLOT >= 8) && (BRIGHT_W >= 1) && (BRIGHT_W <= 3)
                          && (DIGITS >= 2) && (DIGITS <= 8);

    localparam logic [DIGITS-1:0] PIN_OFF = {DIGITS{AL}};
    localparam logic [6:0]        SEG_OFF = {7{AL}};

    logic [PW-1:0]     r_presc;
    logic [IW-1:0]     r_idx;
    logic [SW-1:0]     r_shadow;
    logic              r_pending;
    logic [DIGITS-1:0] r_pin;
    logic [6:0]        r_seg;
    logic              r_dp;
    logic              r_tick;

    logic              w_pwrap;
    logic              w_fwrap;
    logic              w_load;
    logic [SW-1:0]     w_frame;
    logic [3:0]        w_code;
    logic              w_dpsel;
    logic              w_zero;
    logic              w_blank;
    logic [6:0]        w_glyph;
    logic [31:0]       w_on;
    logic              w_lit;
    logic [DIGITS-1:0] w_onehot;

    assign w_pwrap  = (r_presc == PW'(SLOT - 1));
    assign w_fwrap  = w_pwrap && (r_idx == IW'(DIGITS - 1));
    assign w_load   = bus.i_enable && (r_pending || w_fwrap);
    assign w_onehot = DIGITS'(1) << r_idx;

    // The pending load is shown on the very cycle it happens, so the
    // first slot after reset never flashes the stale snapshot.
    assign w_frame = r_pending ? {bus.i_bcd, bus.i_dp} : r_shadow;

    always_comb begin
        w_code  = 4'd0;
        w_dpsel = 1'b0;
        w_blank = 1'b0;
        w_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero = w_zero && (w_frame[DIGITS+4*i +: 4] == 4'd0);
            if (r_idx == IW'(i)) begin
                w_code  = w_frame[DIGITS+4*i +: 4];
                w_dpsel = w_frame[i];
                w_blank = bus.i_blank_lz && (i != 0) && w_zero;
            end
        end
    end

    always_comb begin
        case (w_code)
            4'h0:    w_glyph = 7'b0111111;
            4'h1:    w_glyph = 7'b0000110;
            4'h2:    w_glyph = 7'b1011011;
            4'h3:    w_glyph = 7'b1001111;
            4'h4:    w_glyph = 7'b1100110;
            4'h5:    w_glyph = 7'b1101101;
            4'h6:    w_glyph = 7'b1111101;
            4'h7:    w_glyph = 7'b0000111;
            4'h8:    w_glyph = 7'b1111111;
            4'h9:    w_glyph = 7'b1101111;
            4'hA:    w_glyph = 7'b1110111;
            4'hB:    w_glyph = 7'b1111100;
            4'hC:    w_glyph = 7'b0111001;
            4'hD:    w_glyph = 7'b1011110;
            4'hE:    w_glyph = 7'b1111001;
            default: w_glyph = 7'b1110001;
        endcase
    end

    assign w_on  = ((32'(bus.i_brightness) + 32'd1) * 32'(SLOT)) >> BRIGHT_W;
    assign w_lit = (32'(r_presc) < w_on);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_presc   <= '0;
            r_idx     <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b1;
            r_pin     <= PIN_OFF;
            r_seg     <= SEG_OFF;
            r_dp      <= AL;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_load;
            if (bus.i_enable) begin
                r_presc <= w_pwrap ? '0 : r_presc + PW'(1);
                if (w_pwrap)
                    r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
                if (w_load) begin
                    r_shadow  <= {bus.i_bcd, bus.i_dp};
                    r_pending <= 1'b0;
                end
                r_pin <= (w_lit ? w_onehot : '0) ^ PIN_OFF;
                r_seg <= ((w_lit && !w_blank) ? w_glyph : 7'd0) ^ SEG_OFF;
                r_dp  <= (w_lit && w_dpsel) ^ AL;
            end else begin
                r_pin <= PIN_OFF;
                r_seg <= SEG_OFF;
                r_dp  <= AL;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        assert (P_OK) else $error("scan_display: bad parameters");
    end

    assign bus.o_pin        = r_pin;
    assign bus.o_seg_7      = r_seg;
    assign bus.o_dp_out     = r_dp;
    assign bus.o_frame_tick = r_tick;
endmodule

// File: doc/scan_display.md
Name: scan_display

Overview:
- Parameterised multiplexed seven-segment display driver; next generation of the 4-digit front end.
- Scans N digits of packed BCD/hex onto one shared segment bus plus one enable line per digit.
- Adds an internal scan prescaler, PWM brightness, leading-zero blanking, decimal points and tear-free frame latching.
- Sits between the bin2bcd/data path and the board pins.

Parameters:
- DIGITS, 4: number of digits scanned (2..8).
- CLK_HZ, 50000000: input clock frequency in Hz.
- SCAN_HZ, 2000: digit-slot rate in Hz; slot length SLOT = CLK_HZ/SCAN_HZ cycles (integer, >= 8).
- BRIGHT_W, 3: brightness control width.
- ACTIVE_LOW, 1: 1 = pin, seg_7 and dp_out are driven active-low at the outputs; 0 = active-high.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- bcd  input  4*DIGITS  packed digit codes; digit 0 (ones) is at [3:0].
- dp  input  DIGITS  decimal point request per digit.
- blank_lz  input  1  1 = enable leading-zero blanking.
- brightness  input  BRIGHT_W  duty control; 0 = dimmest, all-ones = full on.
- enable  input  1  0 = display dark and scan frozen.
- pin  output  DIGITS  digit enables; pin[i] drives digit i.
- seg_7  output  7  segments {g,f,e,d,c,b,a}.
- dp_out  output  1  decimal point segment.
- frame_tick  output  1  one-cycle pulse when a new frame snapshot is latched.

Behaviour:
- Polarity: all internal logic is active-high. When ACTIVE_LOW=1, pin, seg_7 and dp_out are inverted at the output registers. "Inactive" below means all digits off, all segments off and dp off after that polarity is applied.
- Reset (rst=1 at a clk edge): prescaler=0, digit index=0, shadow register=0, load_pending=1. Outputs go inactive and frame_tick=0 on the same edge.
- Prescaler:
  - Counts 0..SLOT-1 and wraps.
  - On wrap, the digit index increments modulo DIGITS (DIGITS-1 -> 0).
  - Prescaler and index hold their values while enable=0.
- Frame latch:
  - The shadow register loads {bcd, dp} on the cycle the index wraps DIGITS-1 -> 0.
  - It also loads on the first enabled cycle with load_pending=1; that load clears load_pending.
  - frame_tick=1 on exactly the cycles the shadow loads.
  - Changes to bcd/dp mid-frame are never visible until the next load.
- Decode (combinational from shadow code c of the current digit):
  - 0-9 use standard patterns; 0 = 0111111 and 8 = 1111111.
  - 10-15 display A, b, C, d, E, F.
- Leading-zero blanking: digit i (i >= 1) is blanked when blank_lz=1 and shadow codes i..DIGITS-1 are all zero. Digit 0 is never blanked.
- Blanked digit: segments off, dp still honoured, and the pin stays asserted.
- Brightness:
  - ON = ((brightness+1)*SLOT) >> BRIGHT_W.
  - The digit is lit only while prescaler < ON; otherwise outputs are inactive.
  - brightness all-ones gives ON = SLOT (100 %).
  - brightness 0 gives SLOT/2^BRIGHT_W cycles, which is never 0 because SLOT >= 8 and BRIGHT_W <= 3 is enforced by assertion.
- Output timing:
  - pin, seg_7 and dp_out are registered, with a one-cycle latency from the prescaler/index state.
  - Exactly one pin bit is active when lit; none are active otherwise.
  - Segment and pin changes take effect on the same edge, so there is no ghosting between digits.
- enable=0: outputs go inactive on the next edge and counters freeze. Re-asserting enable resumes from the frozen state.
- Simultaneous events:
  - rst has priority over everything.
  - enable=0 suppresses a frame wrap, so no load and no frame_tick occur.
  - A brightness change takes effect on the next cycle. It is not synchronised to frame boundaries.

Test Plan:
- Reset: DIGITS=4, CLK_HZ=1000, SCAN_HZ=100 (SLOT=10), ACTIVE_LOW=1; hold rst 3 cycles.
  - Required: pin=4'b1111 and seg_7=7'h7F throughout.
  - First enabled cycle after rst falls: frame_tick=1.
- Scan order: bcd=16'h1234, brightness=7.
  - Required: pin[0] low for cycles 1-10 with seg_7=~7'b1100110 ("4").
  - Then pin[1] shows "3", then pin[2] "2", then pin[3] "1".
  - frame_tick pulses every 40 cycles.
- Blanking: bcd=16'h0070, blank_lz=1.
  - Digits 3 and 2: pin asserted, seg_7=7'h7F.
  - Digit 1 shows "7"; digit 0 shows "0".
  - With blank_lz=0, all four digits are visible.
- Brightness: SLOT=16, BRIGHT_W=3, brightness=1.
  - Each pin is active exactly 4 of 16 cycles.
  - brightness=7 gives 16 of 16 cycles.
- Tear-free latch: change bcd from 16'h1111 to 16'h9999 while digit 1 is being shown.
  - Digits 2-3 still show "1" for that frame.
  - "9" appears on all digits only after the next frame_tick.
- Enable/hex: deassert enable mid-slot for 5 cycles.
  - Outputs inactive within 1 cycle and the prescaler value is unchanged on resume.
  - bcd nibble 4'hE displays 7'b1111001.
